uart_transmitter: RTL and testbench

//  Serialises bytes into 11-bit UART frames: start(0), 8 data LSB-first, even parity, stop(1).

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_transmitter.sv | 124 ++++++++++++
 tb/tb_uart_transmitter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame layout, baud divisors and frame helpers.
// Used by the transmitter, the receiver and baud_generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int FRAME_W   = 11;
    localparam int START_POS = 0;
    localparam int PAR_POS   = 9;
    localparam int STOP_POS  = 10;

    // 16x oversampling tick divisors from a 50 MHz clock
    localparam int BAUD_DIV_100   = 31250;
    localparam int BAUD_DIV_400   = 7813;
    localparam int BAUD_DIV_9600  = 325;
    localparam int BAUD_DIV_19200 = 162;

    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data, input logic par);
        logic [FRAME_W-1:0] f;
        f            = '0;
        f[STOP_POS]  = 1'b1;
        f[PAR_POS]   = par;
        f[8:1]       = data;
        f[START_POS] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, parity, stop; paced by the intx baud tick.
// A one-deep holding buffer lets the next byte be accepted while a frame is on the line.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               intx,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_serial,
    output logic [FRAME_W-1:0] out_tx,
    output logic               tx_busy,
    output logic               tx_done
);

    uart_state_t        state_q, state_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic               hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic               tx_serial_q, tx_serial_d;
    logic [FRAME_W-1:0] out_tx_q, out_tx_d;
    logic               tx_done_q, tx_done_d;

    logic accept;
    logic load;

    assign accept = tx_valid & ~hold_valid_q;
    // A frame loads from IDLE or straight out of STOP (back-to-back); never coincides with accept
    assign load   = intx & hold_valid_q & ((state_q == IDLE) | (state_q == STOP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            tx_serial_q  <= 1'b1;
            out_tx_q     <= '1;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_serial_q  <= tx_serial_d;
            out_tx_q     <= out_tx_d;
            tx_done_q    <= tx_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (intx && hold_valid_q) state_d = START;
            START:   if (intx) state_d = DATA;
            DATA:    if (intx && bit_cnt_q == 3'(DATA_W - 1)) state_d = PARITY;
            PARITY:  if (intx) state_d = STOP;
            STOP:    if (intx) state_d = hold_valid_q ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        tx_serial_d  = tx_serial_q;
        out_tx_d     = out_tx_q;
        tx_done_d    = 1'b0;

        if (accept) begin
            hold_data_d  = tx_data;
            hold_valid_d = 1'b1;
        end

        if (intx) begin
            case (state_q)
                START: begin
                    tx_serial_d = shreg_q[0];
                    bit_cnt_d   = '0;
                end
                DATA: begin
                    if (bit_cnt_q != 3'(DATA_W - 1)) begin
                        shreg_d     = shreg_q >> 1;
                        tx_serial_d = shreg_q[1];
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                    end else begin
                        // parity was fixed into the frame image at load time
                        tx_serial_d = out_tx_q[PAR_POS];
                    end
                end
                PARITY: tx_serial_d = 1'b1;
                STOP: begin
                    tx_done_d   = 1'b1;
                    tx_serial_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (load) begin
            hold_valid_d = 1'b0;
            shreg_d      = hold_data_q;
            out_tx_d     = build_frame(hold_data_q, frame_parity(hold_data_q, PARITY_ODD));
            tx_serial_d  = 1'b0;
        end
    end

    assign tx_ready  = ~hold_valid_q;
    assign tx_serial = tx_serial_q;
    assign out_tx    = out_tx_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: even- and odd-parity instances share one stimulus stream.
module tb_uart_transmitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        intx = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;

    logic        rdy_e, ser_e, busy_e, done_e;
    logic        rdy_o, ser_o, busy_o, done_o;
    logic [10:0] otx_e, otx_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .intx(intx), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_e), .tx_serial(ser_e), .out_tx(otx_e), .tx_busy(busy_e), .tx_done(done_e)
    );

    uart_transmitter #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .intx(intx), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_o), .tx_serial(ser_o), .out_tx(otx_o), .tx_busy(busy_o), .tx_done(done_o)
    );

    typedef struct {
        logic [7:0]  data;
        logic [10:0] fe;   // expected frame, even parity
        logic [10:0] fo;   // expected frame, odd parity
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic tk);
        intx = tk;
        @(posedge clk);
        #1;
        intx = 1'b0;
    endtask

    // One bit period: 15 quiet clocks then the tick
    task automatic tick_period();
        for (int i = 0; i < 15; i++) step(1'b0);
        step(1'b1);
    endtask

    task automatic accept_byte(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        step(1'b0);
        tx_valid = 1'b0;
        chk("accept_ready_low", {31'd0, rdy_e}, 32'd0);
    endtask

    task automatic run_bits(input logic [10:0] fe, input logic [10:0] fo, input int k0, input int k1,
                            input logic done0, input logic rdy_chk, input logic rdy_exp);
        for (int k = k0; k <= k1; k++) begin
            tick_period();
            chk($sformatf("serial_even_bit%0d", k), {31'd0, ser_e}, {31'd0, fe[k]});
            chk($sformatf("serial_odd_bit%0d", k), {31'd0, ser_o}, {31'd0, fo[k]});
            chk("busy", {31'd0, busy_e}, 32'd1);
            if (k == 0) begin
                chk("out_tx_even", {21'd0, otx_e}, {21'd0, fe});
                chk("out_tx_odd", {21'd0, otx_o}, {21'd0, fo});
                chk("done_at_load", {31'd0, done_e}, {31'd0, done0});
            end
            if (rdy_chk) chk($sformatf("ready_bit%0d", k), {31'd0, rdy_e}, {31'd0, rdy_exp});
        end
    endtask

    task automatic end_frame();
        tick_period();
        chk("done_pulse", {31'd0, done_e}, 32'd1);
        chk("done_pulse_odd", {31'd0, done_o}, 32'd1);
        chk("idle_busy", {31'd0, busy_e}, 32'd0);
        chk("idle_line", {31'd0, ser_e}, 32'd1);
        step(1'b0);
        chk("done_one_clk", {31'd0, done_e}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 11'h54A, 11'h74A};
        vecs[1] = '{8'h00, 11'h400, 11'h600};
        vecs[2] = '{8'hFF, 11'h5FE, 11'h7FE};
        vecs[3] = '{8'h3C, 11'h478, 11'h678};
        vecs[4] = '{8'h01, 11'h602, 11'h402};
        vecs[5] = '{8'h80, 11'h700, 11'h500};
        vecs[6] = '{8'h5A, 11'h4B4, 11'h6B4};

        // Reset held 3 clocks with tx_valid asserted
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        step(1'b1); step(1'b0); step(1'b1);
        chk("rst_serial", {31'd0, ser_e}, 32'd1);
        chk("rst_out_tx", {21'd0, otx_e}, 32'h7FF);
        chk("rst_ready", {31'd0, rdy_e}, 32'd1);
        chk("rst_busy", {31'd0, busy_e}, 32'd0);
        chk("rst_done", {31'd0, done_e}, 32'd0);
        tx_valid = 1'b0;
        reset    = 1'b1;
        step(1'b0);
        chk("post_rst_ready", {31'd0, rdy_e}, 32'd1);

        // Single frames from IDLE
        for (int i = 0; i < 7; i++) begin
            accept_byte(vecs[i].data);
            run_bits(vecs[i].fe, vecs[i].fo, 0, 10, 1'b0, 1'b0, 1'b0);
            end_frame();
        end

        // Accept and tick on the same edge: load waits for the following tick
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        step(1'b1);
        tx_valid = 1'b0;
        chk("same_edge_not_busy", {31'd0, busy_e}, 32'd0);
        chk("same_edge_line", {31'd0, ser_e}, 32'd1);
        chk("same_edge_ready", {31'd0, rdy_e}, 32'd0);
        run_bits(11'h54A, 11'h74A, 0, 10, 1'b0, 1'b0, 1'b0);
        end_frame();

        // Back-to-back: 0x00 then 0xFF pushed during DATA
        accept_byte(8'h00);
        run_bits(11'h400, 11'h600, 0, 3, 1'b0, 1'b1, 1'b1);
        accept_byte(8'hFF);
        run_bits(11'h400, 11'h600, 4, 10, 1'b0, 1'b1, 1'b0);
        run_bits(11'h5FE, 11'h7FE, 0, 0, 1'b1, 1'b1, 1'b1);
        run_bits(11'h5FE, 11'h7FE, 1, 10, 1'b0, 1'b0, 1'b0);
        end_frame();

        // Backpressure: 0x3C presented while 0x80 sits in hold
        accept_byte(8'h5A);
        run_bits(11'h4B4, 11'h6B4, 0, 1, 1'b0, 1'b0, 1'b0);
        accept_byte(8'h80);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        run_bits(11'h4B4, 11'h6B4, 2, 10, 1'b0, 1'b1, 1'b0);
        run_bits(11'h700, 11'h500, 0, 0, 1'b1, 1'b1, 1'b1);
        step(1'b0);
        tx_valid = 1'b0;
        chk("bp_accept_after_ready", {31'd0, rdy_e}, 32'd0);
        run_bits(11'h700, 11'h500, 1, 10, 1'b0, 1'b0, 1'b0);
        run_bits(11'h478, 11'h678, 0, 0, 1'b1, 1'b1, 1'b1);
        run_bits(11'h478, 11'h678, 1, 10, 1'b0, 1'b0, 1'b0);
        end_frame();

        // Reset during DATA bit 4 with a byte waiting in hold
        accept_byte(8'h5A);
        run_bits(11'h4B4, 11'h6B4, 0, 2, 1'b0, 1'b0, 1'b0);
        accept_byte(8'hFF);
        run_bits(11'h4B4, 11'h6B4, 3, 5, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_serial", {31'd0, ser_e}, 32'd1);
        chk("midrst_ready", {31'd0, rdy_e}, 32'd1);
        chk("midrst_busy", {31'd0, busy_e}, 32'd0);
        chk("midrst_out_tx", {21'd0, otx_e}, 32'h7FF);
        step(1'b1);
        step(1'b0);
        reset = 1'b1;
        tick_period();
        chk("midrst_no_done", {31'd0, done_e}, 32'd0);
        chk("midrst_no_load", {31'd0, busy_e}, 32'd0);
        chk("midrst_line", {31'd0, ser_e}, 32'd1);

        // Clean frame 0x01 after reset, with a 100-clock tick gap mid-frame
        accept_byte(8'h01);
        run_bits(11'h602, 11'h402, 0, 5, 1'b0, 1'b0, 1'b0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                step(1'b0);
                if (ser_e !== 1'b0 || ser_o !== 1'b0 || otx_e !== 11'h602 || otx_o !== 11'h402 ||
                    busy_e !== 1'b1 || done_e !== 1'b0 || rdy_e !== 1'b1)
                    bad++;
            end
            chk("freeze_cycles_bad", bad, 0);
        end
        run_bits(11'h602, 11'h402, 6, 10, 1'b0, 1'b0, 1'b0);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
